// File: rtl/pulse_monitor.sv
// Measures start-to-pulse delay and pulse width of a pulse_generator output and flags mismatches.
// Optional PULSE_MONITOR_STATS_EN adds saturating pass/fail counters.
module pulse_monitor #(
  parameter int CNT_W         = 16,
  parameter int start_delay_p = 3,
  parameter int pulse_width_p = 5,
  parameter int timeout_p     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pulse_in,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_delay,
  output logic [CNT_W-1:0] meas_width,
  output logic             delay_err,
  output logic             width_err,
  output logic             timeout_err,
  output logic             spurious_err,
`ifdef PULSE_MONITOR_STATS_EN
  output logic             overlap_err,
  output logic [15:0]      pass_count,
  output logic [15:0]      fail_count
`else
  output logic             overlap_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HIGH} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(timeout_p);
  localparam logic [CNT_W-1:0] DELAY_C   = CNT_W'(start_delay_p);
  localparam logic [CNT_W-1:0] WIDTH_C   = CNT_W'(pulse_width_p);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             pulse_q;
  logic             rise;
  logic             rep;
  logic             rep_to;
  logic [CNT_W-1:0] rep_delay, rep_width;
  logic             rep_fail;

  assign rise     = pulse_in & ~pulse_q;
  assign busy     = (state_q != S_IDLE);
  assign rep_fail = (rep_delay != DELAY_C) | (rep_width != WIDTH_C) | rep_to;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    delay_d   = delay_q;
    rep       = 1'b0;
    rep_to    = 1'b0;
    rep_delay = '0;
    rep_width = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          cnt_d   = ONE_C;
        end
      end
      S_WAIT: begin
        // A fresh rising edge wins over a timeout landing on the same edge
        if (rise) begin
          state_d = S_HIGH;
          delay_d = cnt_q;
          cnt_d   = ONE_C;
        end else if (cnt_q == TIMEOUT_C) begin
          rep       = 1'b1;
          rep_to    = 1'b1;
          rep_delay = TIMEOUT_C;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_HIGH: begin
        if (!pulse_in) begin
          rep       = 1'b1;
          rep_delay = delay_q;
          rep_width = cnt_q;
          state_d   = S_IDLE;
        end else if (cnt_q == TIMEOUT_C) begin
          rep       = 1'b1;
          rep_to    = 1'b1;
          rep_delay = delay_q;
          rep_width = TIMEOUT_C;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      delay_q      <= '0;
      pulse_q      <= 1'b0;
      meas_valid   <= 1'b0;
      meas_delay   <= '0;
      meas_width   <= '0;
      delay_err    <= 1'b0;
      width_err    <= 1'b0;
      timeout_err  <= 1'b0;
      spurious_err <= 1'b0;
      overlap_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      delay_q      <= delay_d;
      pulse_q      <= pulse_in;
      meas_valid   <= rep;
      delay_err    <= rep & (rep_delay != DELAY_C);
      width_err    <= rep & (rep_width != WIDTH_C);
      timeout_err  <= rep_to;
      spurious_err <= (state_q == S_IDLE) & rise;
      overlap_err  <= (state_q != S_IDLE) & start;
      if (rep) begin
        meas_delay <= rep_delay;
        meas_width <= rep_width;
      end
    end
  end

`ifdef PULSE_MONITOR_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (rep) begin
      if (rep_fail) fail_count <= sat_inc16(fail_count);
      else          pass_count <= sat_inc16(pass_count);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = rep_fail ^ ^sat_inc16(16'h0);
`endif

endmodule

// File: tb/tb_pulse_monitor.sv
// Self-checking bench for pulse_monitor: timestamp-based reference model, directed and randomized stimulus.
module tb_pulse_monitor;
  localparam int CNT_W = 16;
  localparam int SD    = 3;
  localparam int PW    = 5;
  localparam int TO    = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             pulse_in = 1'b0;
  logic             busy, meas_valid, delay_err, width_err, timeout_err, spurious_err, overlap_err;
  logic [CNT_W-1:0] meas_delay, meas_width;
`ifdef PULSE_MONITOR_STATS_EN
  logic [15:0]      pass_count, fail_count;
`endif

  always #5 clk = ~clk;

  pulse_monitor #(.CNT_W(CNT_W), .start_delay_p(SD), .pulse_width_p(PW), .timeout_p(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .pulse_in(pulse_in),
    .busy(busy), .meas_valid(meas_valid), .meas_delay(meas_delay), .meas_width(meas_width),
    .delay_err(delay_err), .width_err(width_err), .timeout_err(timeout_err),
    .spurious_err(spurious_err),
`ifdef PULSE_MONITOR_STATS_EN
    .overlap_err(overlap_err), .pass_count(pass_count), .fail_count(fail_count)
`else
    .overlap_err(overlap_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: measurement expressed as differences of edge timestamps
  int  k = 0;
  bit  m_pending, m_high, m_prev;
  int  m_ts, m_tr, m_d;
  bit  e_busy, e_valid, e_derr, e_werr, e_terr, e_spur, e_ovl;
  logic [15:0] e_delay, e_width;
  logic [15:0] e_pass, e_fail;

  task automatic model_clear();
    m_pending = 0; m_high = 0; m_prev = 0;
    e_busy = 0; e_valid = 0; e_derr = 0; e_werr = 0; e_terr = 0; e_spur = 0; e_ovl = 0;
    e_delay = 0; e_width = 0; e_pass = 0; e_fail = 0;
  endtask

  task automatic model_report(input int d, input int w, input bit to);
    e_valid = 1; e_delay = 16'(d); e_width = 16'(w);
    e_derr = (d != SD); e_werr = (w != PW); e_terr = to;
    if (e_derr || e_werr || to) begin
      if (e_fail != 16'hFFFF) e_fail = e_fail + 1;
    end else begin
      if (e_pass != 16'hFFFF) e_pass = e_pass + 1;
    end
    m_pending = 0;
  endtask

  task automatic model_step(input bit s, input bit p);
    bit rise;
    rise = p & ~m_prev;
    e_valid = 0; e_derr = 0; e_werr = 0; e_terr = 0; e_spur = 0; e_ovl = 0;
    if (!m_pending) begin
      if (rise) e_spur = 1;
      if (s) begin m_pending = 1; m_high = 0; m_ts = k; end
    end else begin
      if (s) e_ovl = 1;
      if (!m_high) begin
        if (rise) begin m_high = 1; m_tr = k; m_d = k - m_ts; end
        else if (k - m_ts == TO) model_report(TO, 0, 1);
      end else begin
        if (!p) model_report(m_d, k - m_tr, 0);
        else if (k - m_tr == TO) model_report(m_d, TO, 1);
      end
    end
    m_prev = p;
    e_busy = m_pending;
  endtask

  task automatic compare(input string name);
    chk(name, {25'd0, busy, meas_valid, delay_err, width_err, timeout_err, spurious_err, overlap_err,
               meas_delay, meas_width},
              {25'd0, e_busy, e_valid, e_derr, e_werr, e_terr, e_spur, e_ovl, e_delay, e_width});
`ifdef PULSE_MONITOR_STATS_EN
    chk({name, "_stats"}, {32'd0, pass_count, fail_count}, {32'd0, e_pass, e_fail});
`endif
  endtask

  // Observations of DUT strobes for the directed literal checks
  int n_valid, n_spur, n_ovl;
  logic [15:0] r_delay, r_width;
  logic r_derr, r_werr, r_terr, r_busy;

  task automatic clr_obs();
    n_valid = 0; n_spur = 0; n_ovl = 0;
    r_delay = 'x; r_width = 'x; r_derr = 'x; r_werr = 'x; r_terr = 'x; r_busy = 'x;
  endtask

  task automatic run_cycle(input bit s, input bit p);
    start = s; pulse_in = p;
    @(posedge clk);
    k++;
    model_step(s, p);
    #1;
    compare("cycle_outputs");
    if (meas_valid === 1'b1) begin
      n_valid++;
      r_delay = meas_delay; r_width = meas_width;
      r_derr = delay_err; r_werr = width_err; r_terr = timeout_err; r_busy = busy;
    end
    if (spurious_err === 1'b1) n_spur++;
    if (overlap_err === 1'b1) n_ovl++;
  endtask

  task automatic txn(input int d, input int w, input int ovl);
    for (int t = 0; t <= d + w + 1; t++) run_cycle((t == 0) || (t == ovl), (t >= d) && (t < d + w));
  endtask

  task automatic do_reset(input int n);
    start = 0; pulse_in = 0; reset = 0;
    #1;
`ifdef PULSE_MONITOR_STATS_EN
    model_clear();
`else
    model_clear();
`endif
    compare("reset_async");
    repeat (n) begin
      @(posedge clk); #1;
      compare("reset_hold");
    end
    reset = 1;
  endtask

  initial begin
    model_clear();
    clr_obs();
    repeat (3) @(posedge clk);
    #1;
    compare("reset_state");
    reset = 1;
    repeat (3) run_cycle(0, 0);

`ifdef PULSE_MONITOR_STATS_EN
    repeat (3) txn(3, 5, -1);
    repeat (2) txn(4, 2, -1);
    chk("stats_pass", pass_count, 16'd3);
    chk("stats_fail", fail_count, 16'd2);
    force dut.fail_count = 16'hFFFF;
    e_fail = 16'hFFFF;
    run_cycle(0, 0);
    release dut.fail_count;
    txn(4, 2, -1);
    chk("stats_fail_sat", fail_count, 16'hFFFF);
`endif

    // Nominal 3/5 measurement
    clr_obs();
    txn(3, 5, -1);
    chk("nom_valid_cnt", n_valid, 1);
    chk("nom_delay", r_delay, 3);
    chk("nom_width", r_width, 5);
    chk("nom_errs", {r_derr, r_werr, r_terr}, 3'b000);

    // Off-nominal 4/2
    clr_obs();
    txn(4, 2, -1);
    chk("off_delay", r_delay, 4);
    chk("off_width", r_width, 2);
    chk("off_errs", {r_derr, r_werr, r_terr}, 3'b110);

    // No pulse: wait-phase timeout
    clr_obs();
    run_cycle(1, 0);
    repeat (66) run_cycle(0, 0);
    chk("to_valid_cnt", n_valid, 1);
    chk("to_delay", r_delay, 64);
    chk("to_width", r_width, 0);
    chk("to_flag", r_terr, 1'b1);
    chk("to_busy_after", r_busy, 1'b0);

    // Spurious pulse in idle, then overlapping start during high phase
    clr_obs();
    repeat (3) run_cycle(0, 1);
    repeat (2) run_cycle(0, 0);
    chk("spur_cnt", n_spur, 1);
    chk("spur_no_valid", n_valid, 0);
    clr_obs();
    txn(3, 5, 5);
    chk("ovl_cnt", n_ovl, 1);
    chk("ovl_delay", r_delay, 3);
    chk("ovl_width", r_width, 5);

    // Reset mid-high discards the measurement
    clr_obs();
    for (int t = 0; t < 6; t++) run_cycle(t == 0, t >= 3);
    do_reset(2);
    repeat (3) run_cycle(0, 0);
    chk("rst_no_valid", n_valid, 0);
    txn(3, 5, -1);
    chk("rst_after_delay", r_delay, 3);
    chk("rst_after_width", r_width, 5);

    // Randomized traffic
    repeat (150) begin
      int kind, d, w, o;
      kind = $urandom_range(0, 9);
      d = $urandom_range(1, 7);
      w = $urandom_range(1, 9);
      o = ($urandom_range(0, 3) == 0) ? $urandom_range(1, d + w) : -1;
      if (kind <= 5) txn(d, w, o);
      else if (kind <= 7) begin
        repeat ($urandom_range(3, 12)) run_cycle($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
      end else if (kind == 8) txn(d, $urandom_range(62, 70), o);
      else txn(1, 1, -1);
    end
    repeat (70) run_cycle(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
